// File: rtl/gpr_file_pkg.sv
// Shared constants for the general-purpose register file: special-register
// addresses, STATUS reset value, writeCommand bit positions and TMR0 timing.
package gpr_file_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ADDR_INDF   = 5'h00;
    localparam logic [ADDR_W-1:0] ADDR_TMR0   = 5'h01;
    localparam logic [ADDR_W-1:0] ADDR_PCL    = 5'h02;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 5'h03;
    localparam logic [ADDR_W-1:0] ADDR_FSR    = 5'h04;
    localparam logic [ADDR_W-1:0] ADDR_STORE0 = 5'h05;

    localparam logic [DATA_W-1:0] STATUS_RST = 8'h18;

    localparam int CMD_ADDR   = 2;
    localparam int CMD_GPR    = 1;
    localparam int CMD_STATUS = 0;

    // Ticks swallowed after a TMR0 write
    localparam logic [1:0] TMR_SUPPRESS = 2'd2;

endpackage

// File: rtl/gpr_file_tmr0_counter.sv
// TMR0 free-running counter: increments once per tick, and after a load
// ignores the next two ticks (plus any tick coinciding with the load).
module tmr0_counter
    import gpr_file_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              load,
    input  logic [DATA_W-1:0] loadData,
    output logic [DATA_W-1:0] count
);

    logic [1:0] suppressCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            suppressCnt <= '0;
        end else if (load) begin
            count       <= loadData;
            suppressCnt <= TMR_SUPPRESS;
        end else if (tick) begin
            if (suppressCnt != 2'd0)
                suppressCnt <= suppressCnt - 2'd1;
            else
                count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/gpr_file.sv
// Register file with INDF/TMR0/PCL/STATUS/FSR specials and byte storage.
// Define GPR_BANKING_EN to bank 0x10-0x1F four ways by FSR[6:5].
module gpr_file
    import gpr_file_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        writeCommand,
    input  logic [DATA_W-1:0] gprWriteData,
    input  logic [DATA_W-1:0] statusWriteData,
    input  logic              tmrTick,
    output logic [DATA_W-1:0] readData,
    output logic [DATA_W-1:0] statusOut,
    output logic [DATA_W-1:0] fsrOut,
    output logic              pclWriteEn,
    output logic [DATA_W-1:0] pclWriteData
);

    logic [ADDR_W-1:0] addrReg;
    logic [ADDR_W-1:0] effAddr;
    logic [DATA_W-1:0] fsr;
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] statusNext;
    logic [DATA_W-1:0] tmr0;
    logic [DATA_W-1:0] storeRd;
    logic              gprWrite;
    logic              storeWrite;

    assign gprWrite   = writeCommand[CMD_GPR];
    assign effAddr    = (addrReg == ADDR_INDF) ? fsr[ADDR_W-1:0] : addrReg;
    assign storeWrite = gprWrite && (effAddr >= ADDR_STORE0);
    assign statusOut  = status;
    assign fsrOut     = fsr;

    tmr0_counter uTmr0 (
        .clk      (clk),
        .rst      (rst),
        .tick     (tmrTick),
        .load     (gprWrite && (effAddr == ADDR_TMR0)),
        .loadData (gprWriteData),
        .count    (tmr0)
    );

`ifdef GPR_BANKING_EN
    // 0x05-0x0F shared; 0x10-0x1F banked by FSR[6:5]
    logic [DATA_W-1:0] sharedMem [0:10];
    logic [DATA_W-1:0] bankMem   [0:63];
    logic [3:0]        sharedIdx;
    logic [5:0]        bankIdx;

    assign sharedIdx = effAddr[3:0] - 4'd5;
    assign bankIdx   = {fsr[6:5], effAddr[3:0]};
    assign storeRd   = effAddr[4] ? bankMem[bankIdx] : sharedMem[sharedIdx];

    always_ff @(posedge clk) begin
        if (storeWrite) begin
            if (effAddr[4])
                bankMem[bankIdx] <= gprWriteData;
            else
                sharedMem[sharedIdx] <= gprWriteData;
        end
    end
`else
    logic [DATA_W-1:0] mem [0:26];
    logic [4:0]        memIdx;

    assign memIdx  = effAddr - ADDR_STORE0;
    assign storeRd = mem[memIdx];

    always_ff @(posedge clk) begin
        if (storeWrite)
            mem[memIdx] <= gprWriteData;
    end
`endif

    // TO/PD (bits 4:3) only change through the write-control STATUS path
    always_comb begin
        statusNext = status;
        if (writeCommand[CMD_STATUS])
            statusNext = statusWriteData;
        if (gprWrite && (effAddr == ADDR_STATUS)) begin
            statusNext[7:5] = gprWriteData[7:5];
            statusNext[4:3] = status[4:3];
            statusNext[2:0] = writeCommand[CMD_STATUS] ? statusWriteData[2:0]
                                                       : gprWriteData[2:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrReg      <= '0;
            fsr          <= '0;
            status       <= STATUS_RST;
            pclWriteEn   <= 1'b0;
            pclWriteData <= '0;
        end else begin
            status     <= statusNext;
            pclWriteEn <= gprWrite && (effAddr == ADDR_PCL);
            if (gprWrite && (effAddr == ADDR_PCL))
                pclWriteData <= gprWriteData;
            if (gprWrite && (effAddr == ADDR_FSR))
                fsr <= gprWriteData;
            if (writeCommand[CMD_ADDR])
                addrReg <= gprWriteData[ADDR_W-1:0];
        end
    end

    always_comb begin
        readData = storeRd;
        case (effAddr)
            ADDR_INDF:   readData = '0;
            ADDR_TMR0:   readData = tmr0;
            ADDR_PCL:    readData = '0;
            ADDR_STATUS: readData = status;
            ADDR_FSR:    readData = fsr;
            default:     readData = storeRd;
        endcase
    end

endmodule
